// File: rtl/fb_mem_arbiter_pkg.sv
// Shared types for the framebuffer memory arbiter: FSM states, memory request
// bundle and bus widths.
package fb_pkg;

  localparam int FB_ADDR_W = 16;
  localparam int FB_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    CPU  = 2'd2
  } fb_arb_state_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] address;
    logic                 wr_en;
    logic [1:0]           bytesel;
    logic [FB_DATA_W-1:0] wr_data;
  } fb_mem_req_t;

endpackage

// File: rtl/fb_arb_counters.sv
// Fairness counters for the framebuffer arbiter: display burst length and CPU
// wait time, both saturating, with hit flags used by the IDLE arbitration.
module fb_arb_counters #(
  parameter int DISP_BURST_MAX   = 8,
  parameter int CPU_STARVE_LIMIT = 32,
  localparam int BW = $clog2(DISP_BURST_MAX) + 1,
  localparam int SW = $clog2(CPU_STARVE_LIMIT) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_access,
  input  logic          in_idle,
  input  logic          in_cpu,
  input  logic          disp_grant,
  input  logic          cpu_grant,
  output logic [BW-1:0] burst_cnt,
  output logic [SW-1:0] starve_cnt,
  output logic          burst_hit,
  output logic          starve_hit
);

  localparam logic [BW-1:0] BURST_LIM  = BW'(DISP_BURST_MAX);
  localparam logic [SW-1:0] STARVE_LIM = SW'(CPU_STARVE_LIMIT);

  assign burst_hit  = (burst_cnt >= BURST_LIM);
  assign starve_hit = (starve_cnt >= STARVE_LIM);

  // Burst only counts display grants that actually delay a waiting CPU.
  always_ff @(posedge clk) begin
    if (!reset) begin
      burst_cnt <= '0;
    end else if (cpu_grant || (in_idle && !cpu_access)) begin
      burst_cnt <= '0;
    end else if (disp_grant && cpu_access && (burst_cnt != '1)) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (cpu_grant) begin
      starve_cnt <= '0;
    end else if (cpu_access && !in_cpu && (starve_cnt < STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Arbitrates the single framebuffer memory port between display prefetch
// (priority) and the CPU bus, with burst and starvation guards for the CPU.
module fb_mem_arbiter
  import fb_pkg::*;
#(
  parameter int DISP_BURST_MAX   = 8,
  parameter int CPU_STARVE_LIMIT = 32,
  localparam int BW = $clog2(DISP_BURST_MAX) + 1,
  localparam int SW = $clog2(CPU_STARVE_LIMIT) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  // Handshake: a requester holds *_access and its fields stable until its
  // one-cycle *_ack; mem_access/mem_* are held until the one-cycle mem_ack.
  input  logic                 disp_access,
  input  logic [FB_ADDR_W-1:0] disp_address,
  output logic                 disp_ack,
  output logic [FB_DATA_W-1:0] disp_data,
  input  logic                 cpu_access,
  input  logic [FB_ADDR_W-1:0] cpu_address,
  input  logic                 cpu_wr_en,
  input  logic [1:0]           cpu_bytesel,
  input  logic [FB_DATA_W-1:0] cpu_wr_data,
  output logic                 cpu_ack,
  output logic [FB_DATA_W-1:0] cpu_data,
  output logic                 mem_access,
  output logic [FB_ADDR_W-1:0] mem_address,
  output logic                 mem_wr_en,
  output logic [1:0]           mem_bytesel,
  output logic [FB_DATA_W-1:0] mem_wr_data,
  input  logic                 mem_ack,
  input  logic [FB_DATA_W-1:0] mem_data,
  output fb_arb_state_t        dbg_state,
  output logic [BW-1:0]        dbg_burst_cnt,
  output logic [SW-1:0]        dbg_starve_cnt
);

  fb_arb_state_t state;
  fb_mem_req_t   disp_req;
  fb_mem_req_t   cpu_req;
  fb_mem_req_t   sel_req;
  logic          cpu_win;
  logic          disp_win;
  logic          burst_hit;
  logic          starve_hit;

  assign dbg_state = state;

  always_comb begin
    disp_req         = '0;
    disp_req.address = disp_address;
    disp_req.wr_en   = 1'b0;
    disp_req.bytesel = 2'b11;

    cpu_req.address  = cpu_address;
    cpu_req.wr_en    = cpu_wr_en;
    cpu_req.bytesel  = cpu_bytesel;
    cpu_req.wr_data  = cpu_wr_data;

    // Display wins ties unless the CPU has waited too long or display has
    // already taken a full burst.
    cpu_win  = (state == IDLE) && cpu_access &&
               (starve_hit || burst_hit || !disp_access);
    disp_win = (state == IDLE) && disp_access && !cpu_win;
    sel_req  = cpu_win ? cpu_req : disp_req;
  end

  fb_arb_counters #(
    .DISP_BURST_MAX  (DISP_BURST_MAX),
    .CPU_STARVE_LIMIT(CPU_STARVE_LIMIT)
  ) u_counters (
    .clk        (clk),
    .reset      (reset),
    .cpu_access (cpu_access),
    .in_idle    (state == IDLE),
    .in_cpu     (state == CPU),
    .disp_grant (disp_win),
    .cpu_grant  (cpu_win),
    .burst_cnt  (dbg_burst_cnt),
    .starve_cnt (dbg_starve_cnt),
    .burst_hit  (burst_hit),
    .starve_hit (starve_hit)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      disp_ack    <= 1'b0;
      cpu_ack     <= 1'b0;
      disp_data   <= '0;
      cpu_data    <= '0;
      mem_access  <= 1'b0;
      mem_address <= '0;
      mem_wr_en   <= 1'b0;
      mem_bytesel <= '0;
      mem_wr_data <= '0;
    end else begin
      disp_ack <= 1'b0;
      cpu_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_win || disp_win) begin
            mem_access  <= 1'b1;
            mem_address <= sel_req.address;
            mem_wr_en   <= sel_req.wr_en;
            mem_bytesel <= sel_req.bytesel;
            mem_wr_data <= sel_req.wr_data;
            state       <= cpu_win ? CPU : DISP;
          end
        end
        DISP: begin
          if (mem_ack) begin
            mem_access <= 1'b0;
            disp_data  <= mem_data;
            disp_ack   <= 1'b1;
            state      <= IDLE;
          end
        end
        CPU: begin
          if (mem_ack) begin
            mem_access <= 1'b0;
            cpu_data   <= mem_data;
            cpu_ack    <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter: default instance for most steps, a
// second instance with a long burst limit to expose the starvation guard.
module tb_fb_mem_arbiter;
  import fb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: default parameters.
  logic        disp_access, disp_ack, cpu_access, cpu_wr_en, cpu_ack;
  logic [15:0] disp_address, disp_data, cpu_address, cpu_wr_data, cpu_data;
  logic [1:0]  cpu_bytesel, mem_bytesel;
  logic        mem_access, mem_wr_en, mem_ack;
  logic [15:0] mem_address, mem_wr_data, mem_data;
  fb_arb_state_t state_a;
  logic [3:0]  burst_a;
  logic [5:0]  starve_a;

  // Instance B: DISP_BURST_MAX = 64, CPU_STARVE_LIMIT = 32.
  logic        disp_access_b, disp_ack_b, cpu_access_b, cpu_ack_b;
  logic [15:0] disp_data_b, cpu_data_b;
  logic [1:0]  mem_bytesel_b;
  logic        mem_access_b, mem_wr_en_b, mem_ack_b;
  logic [15:0] mem_address_b, mem_wr_data_b, mem_data_b;
  fb_arb_state_t state_b;
  logic [6:0]  burst_b;
  logic [5:0]  starve_b;

  fb_mem_arbiter dut_a (
    .clk(clk), .reset(reset),
    .disp_access(disp_access), .disp_address(disp_address),
    .disp_ack(disp_ack), .disp_data(disp_data),
    .cpu_access(cpu_access), .cpu_address(cpu_address), .cpu_wr_en(cpu_wr_en),
    .cpu_bytesel(cpu_bytesel), .cpu_wr_data(cpu_wr_data),
    .cpu_ack(cpu_ack), .cpu_data(cpu_data),
    .mem_access(mem_access), .mem_address(mem_address), .mem_wr_en(mem_wr_en),
    .mem_bytesel(mem_bytesel), .mem_wr_data(mem_wr_data),
    .mem_ack(mem_ack), .mem_data(mem_data),
    .dbg_state(state_a), .dbg_burst_cnt(burst_a), .dbg_starve_cnt(starve_a)
  );

  fb_mem_arbiter #(.DISP_BURST_MAX(64), .CPU_STARVE_LIMIT(32)) dut_b (
    .clk(clk), .reset(reset),
    .disp_access(disp_access_b), .disp_address(16'h2000),
    .disp_ack(disp_ack_b), .disp_data(disp_data_b),
    .cpu_access(cpu_access_b), .cpu_address(16'h3000), .cpu_wr_en(1'b0),
    .cpu_bytesel(2'b00), .cpu_wr_data(16'h0000),
    .cpu_ack(cpu_ack_b), .cpu_data(cpu_data_b),
    .mem_access(mem_access_b), .mem_address(mem_address_b), .mem_wr_en(mem_wr_en_b),
    .mem_bytesel(mem_bytesel_b), .mem_wr_data(mem_wr_data_b),
    .mem_ack(mem_ack_b), .mem_data(mem_data_b),
    .dbg_state(state_b), .dbg_burst_cnt(burst_b), .dbg_starve_cnt(starve_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat_a = 1, lat_b = 10, wait_a = 0, wait_b = 0;
  logic [15:0] rd_a = 16'h0, rd_b = 16'h0;
  bit disp_drop = 1, cpu_drop = 1, disp_drop_b = 1, cpu_drop_b = 1;
  int mem_ack_cyc = -10, disp_ack_cyc = -20, cpu_ack_cyc = -20;
  logic [15:0] last_disp_data, last_cpu_data;
  bit ack_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock step: memory models respond, acks are logged, requesters that
  // finished drop their request.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (!reset) begin
      mem_ack = 1'b0; wait_a = 0;
      mem_ack_b = 1'b0; wait_b = 0;
    end else begin
      if (mem_access && !mem_ack) begin
        if (wait_a == lat_a) begin
          mem_ack = 1'b1; mem_data = rd_a; wait_a = 0; mem_ack_cyc = cyc;
        end else wait_a++;
      end else mem_ack = 1'b0;
      if (mem_access_b && !mem_ack_b) begin
        if (wait_b == lat_b) begin
          mem_ack_b = 1'b1; mem_data_b = rd_b; wait_b = 0;
        end else wait_b++;
      end else mem_ack_b = 1'b0;
    end
    if (disp_ack || cpu_ack) check("ack_exclusive", 32'(disp_ack & cpu_ack), 0);
    if (disp_ack) begin
      ack_log.push_back(1'b0); disp_ack_cyc = cyc; last_disp_data = disp_data;
      if (disp_drop) disp_access = 1'b0;
    end
    if (cpu_ack) begin
      ack_log.push_back(1'b1); cpu_ack_cyc = cyc; last_cpu_data = cpu_data;
      if (cpu_drop) cpu_access = 1'b0;
    end
    if (disp_ack_b && disp_drop_b) disp_access_b = 1'b0;
    if (cpu_ack_b && cpu_drop_b) cpu_access_b = 1'b0;
  endtask

  task automatic wait_ack(input bit is_cpu, input string tag);
    int n = 0;
    while (!(is_cpu ? cpu_ack : disp_ack) && n < 60) begin tick(); n++; end
    check({tag, "_ack_in_time"}, 32'(n < 60), 1);
  endtask

  task automatic drain_a(input string tag);
    int n = 0;
    while ((disp_access || cpu_access || mem_access || state_a != IDLE) && n < 100) begin
      tick(); n++;
    end
    check({tag, "_drain"}, 32'(n < 100), 1);
  endtask

  initial begin
    int n, d_before, disp_grants;
    bit got_cpu;
    fb_arb_state_t prev_state;
    logic [5:0] prev_starve, starve_at_grant;

    reset = 1'b0;
    mem_ack = 1'b0; mem_data = '0; mem_ack_b = 1'b0; mem_data_b = '0;
    disp_access_b = 1'b0; cpu_access_b = 1'b0;
    disp_access = 1'b1; disp_address = 16'h0100;
    cpu_access = 1'b1; cpu_address = 16'h0200; cpu_wr_en = 1'b0;
    cpu_bytesel = 2'b00; cpu_wr_data = 16'h0000;
    rd_a = 16'h1111;

    // Reset held with both requests pending.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mem_access", mem_access, 0);
      check("rst_disp_ack", disp_ack, 0);
      check("rst_cpu_ack", cpu_ack, 0);
      check("rst_state", state_a, IDLE);
    end
    check("rst_mem_bytesel", mem_bytesel, 0);
    check("rst_mem_address", mem_address, 0);
    reset = 1'b1;
    tick();
    check("rel_mem_access", mem_access, 1);
    check("rel_mem_address", mem_address, 16'h0100);
    check("rel_mem_bytesel", mem_bytesel, 2'b11);
    check("rel_mem_wr_en", mem_wr_en, 0);
    check("rel_state", state_a, DISP);
    wait_ack(0, "rel_disp");
    check("rel_disp_data", last_disp_data, 16'h1111);
    wait_ack(1, "rel_cpu");
    check("rel_cpu_data", last_cpu_data, 16'h1111);
    drain_a("rel");

    // Solo CPU write, 2-cycle memory.
    lat_a = 2;
    cpu_address = 16'h0123; cpu_wr_en = 1'b1; cpu_bytesel = 2'b01; cpu_wr_data = 16'hBEEF;
    cpu_access = 1'b1;
    tick();
    check("wr_mem_access", mem_access, 1);
    check("wr_mem_address", mem_address, 16'h0123);
    check("wr_mem_wr_en", mem_wr_en, 1);
    check("wr_mem_bytesel", mem_bytesel, 2'b01);
    check("wr_mem_wr_data", mem_wr_data, 16'hBEEF);
    check("wr_state", state_a, CPU);
    wait_ack(1, "wr");
    check("wr_ack_latency", cpu_ack_cyc - mem_ack_cyc, 1);
    check("wr_mem_access_drop", mem_access, 0);
    tick();
    check("wr_ack_pulse", cpu_ack, 0);
    drain_a("wr");

    // Display read, 1-cycle memory.
    lat_a = 1; rd_a = 16'h1F41;
    disp_address = 16'h0400; disp_access = 1'b1;
    tick();
    check("rd_mem_address", mem_address, 16'h0400);
    check("rd_mem_wr_en", mem_wr_en, 0);
    check("rd_mem_bytesel", mem_bytesel, 2'b11);
    wait_ack(0, "rd");
    check("rd_disp_data", disp_data, 16'h1F41);
    check("rd_ack_latency", disp_ack_cyc - mem_ack_cyc, 1);
    check("rd_cpu_ack", cpu_ack, 0);
    tick();
    check("rd_ack_pulse", disp_ack, 0);
    drain_a("rd");

    // Burst limit: display held, CPU waiting.
    ack_log.delete();
    rd_a = 16'h7E57; disp_address = 16'h0800; disp_drop = 0;
    cpu_address = 16'h0055; cpu_wr_en = 1'b0; cpu_bytesel = 2'b00;
    disp_access = 1'b1; cpu_access = 1'b1;
    n = 0;
    while (ack_log.size() < 10 && n < 400) begin tick(); n++; end
    check("burst_log_len", ack_log.size(), 10);
    d_before = 0;
    for (int i = 0; i < ack_log.size(); i++) begin
      if (ack_log[i]) break;
      d_before++;
    end
    check("burst_disp_count", d_before, 8);
    check("burst_cpu_slot", 32'(ack_log.size() > 8 && ack_log[8]), 1);
    check("burst_resume", 32'(ack_log.size() > 9 && !ack_log[9]), 1);
    check("burst_cpu_data", last_cpu_data, 16'h7E57);
    disp_drop = 1;
    drain_a("burst");

    // Starvation guard on instance B, 10-cycle memory.
    disp_drop_b = 0;
    disp_access_b = 1'b1; cpu_access_b = 1'b1;
    disp_grants = 0; got_cpu = 0; starve_at_grant = '0;
    n = 0;
    while (!got_cpu && n < 300) begin
      prev_state = state_b; prev_starve = starve_b;
      tick(); n++;
      if (prev_state == IDLE && state_b == DISP) disp_grants++;
      if (prev_state == IDLE && state_b == CPU) begin
        got_cpu = 1; starve_at_grant = prev_starve;
      end
    end
    check("starve_cpu_granted", got_cpu, 1);
    check("starve_disp_grants", disp_grants, 3);
    check("starve_cnt_at_grant", starve_at_grant, 32);
    check("starve_cnt_cleared", starve_b, 0);
    check("starve_burst_cleared", burst_b, 0);
    disp_drop_b = 1;
    n = 0;
    while ((disp_access_b || cpu_access_b || mem_access_b || state_b != IDLE) && n < 100) begin
      tick(); n++;
    end
    check("starve_drain", 32'(n < 100), 1);

    // Reset while the CPU transaction is waiting on memory.
    lat_a = 2; cpu_address = 16'h0AAA; cpu_wr_en = 1'b0; cpu_access = 1'b1;
    tick();
    check("mid_state_cpu", state_a, CPU);
    tick();
    check("mid_no_early_ack", mem_ack, 0);
    reset = 1'b0; cpu_access = 1'b0;
    tick();
    check("mid_mem_access", mem_access, 0);
    check("mid_state", state_a, IDLE);
    check("mid_cpu_ack", cpu_ack, 0);
    tick();
    check("mid_cpu_ack_after", cpu_ack, 0);
    reset = 1'b1;
    lat_a = 1;
    cpu_address = 16'h0FF0; cpu_wr_en = 1'b1; cpu_bytesel = 2'b10; cpu_wr_data = 16'hA5A5;
    cpu_access = 1'b1;
    tick();
    check("post_mem_address", mem_address, 16'h0FF0);
    check("post_mem_bytesel", mem_bytesel, 2'b10);
    check("post_mem_wr_data", mem_wr_data, 16'hA5A5);
    wait_ack(1, "post");
    check("post_ack_latency", cpu_ack_cyc - mem_ack_cyc, 1);
    drain_a("post");

    // Stray mem_ack while idle must be ignored.
    mem_ack = 1'b1;
    tick();
    check("stray_disp_ack", disp_ack, 0);
    check("stray_cpu_ack", cpu_ack, 0);
    check("stray_state", state_a, IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_mem_arbiter.md
Name: fb_mem_arbiter

Overview:
- Shares the single 16-bit framebuffer memory port between two requesters: the display prefetch engine (read-only, latency-critical) and the CPU bus (read/write, byte lanes).
- Sits in the sys_clk domain between the framebuffer prefetch logic and the framebuffer RAM controller.
- Display has priority, with a bounded-burst and starvation guard so CPU accesses always complete.

Parameters:
- DISP_BURST_MAX, 8, maximum back-to-back display grants while a CPU request is pending.
- CPU_STARVE_LIMIT, 32, CPU wait cycles after which the CPU wins the next arbitration.

Ports:
- clk  input  1  system clock (sys_clk domain).
- reset  input  1  synchronous, active-low reset.
- disp_access  input  1  display read request; held until disp_ack.
- disp_address  input  16  display word address.
- disp_ack  output  1  one-cycle pulse; disp_data valid this cycle.
- disp_data  output  16  display read data.
- cpu_access  input  1  CPU request; held until cpu_ack.
- cpu_address  input  16  CPU word address.
- cpu_wr_en  input  1  1 = write, 0 = read.
- cpu_bytesel  input  2  byte lane enables for writes.
- cpu_wr_data  input  16  CPU write data.
- cpu_ack  output  1  one-cycle completion pulse.
- cpu_data  output  16  CPU read data, valid with cpu_ack.
- mem_access  output  1  memory request; held until mem_ack.
- mem_address  output  16  memory word address.
- mem_wr_en  output  1  memory write enable.
- mem_bytesel  output  2  memory byte lanes (2'b11 for display reads).
- mem_wr_data  output  16  memory write data.
- mem_ack  input  1  memory completion pulse, read data valid.
- mem_data  input  16  memory read data.

Behaviour:
- States: IDLE, DISP, CPU.
- Reset (reset == 0 at a clk edge) forces:
  - state IDLE; all acks 0; mem_access 0; mem_wr_en 0; mem_bytesel 0; mem_address, mem_wr_data, disp_data and cpu_data 0.
  - burst_cnt and starve_cnt cleared.
  - Reset mid-transaction abandons the transaction and raises no ack.
  - The memory controller shares the same reset.
- IDLE arbitration is evaluated each cycle from registered state. It selects:
  - CPU if cpu_access and (starve_cnt >= CPU_STARVE_LIMIT or burst_cnt >= DISP_BURST_MAX or !disp_access);
  - otherwise DISP if disp_access;
  - otherwise stays in IDLE.
- Grant cycle (registered):
  - Requester fields are latched onto mem_* and mem_access is set on the next edge.
  - The arbiter then moves to DISP or CPU.
  - Latency from request in IDLE to mem_access high is 1 cycle.
- In DISP or CPU:
  - mem_access and mem_* stay stable until mem_ack.
  - On mem_ack: mem_access drops in the same edge, and mem_data is registered into the granted requester's data output.
  - The matching ack pulses for exactly 1 cycle, on the cycle after mem_ack. It is never asserted on both requesters at once.
  - The arbiter returns to IDLE.
  - Minimum back-to-back spacing is 3 cycles per transaction with a 1-cycle memory.
- mem_ack outside DISP/CPU is ignored.
- Requesters must keep request fields stable until their ack. Requester behaviour after ack is unconstrained: a requester may reassert in the ack cycle, and the arbiter samples the request in IDLE.
- burst_cnt (width clog2(DISP_BURST_MAX)+1, saturating):
  - increments on each display grant issued while cpu_access is high;
  - clears on a CPU grant, or when cpu_access is low in IDLE.
- starve_cnt (width clog2(CPU_STARVE_LIMIT)+1, saturating at CPU_STARVE_LIMIT):
  - increments each cycle cpu_access is high and the state is not CPU;
  - clears on a CPU grant.
- Display reads drive mem_wr_en = 0 and mem_bytesel = 2'b11.
- CPU accesses pass cpu_wr_en, cpu_bytesel and cpu_wr_data through unchanged.
- Simultaneous requests in IDLE with both counters below limit: display wins.

Decomposition:
- Shared package fb_pkg holds:
  - typedef enum logic [1:0] fb_arb_state_t {IDLE, DISP, CPU};
  - typedef struct fb_mem_req_t {address, wr_en, bytesel, wr_data};
  - localparam FB_ADDR_W = 16 and FB_DATA_W = 16.
- One sub-module is natural: fb_arb_counters, holding the saturating burst_cnt and starve_cnt with their clear and increment rules.
- The FSM and datapath muxing stay in fb_mem_arbiter.

Test Plan:
- Reset: hold reset = 0 for 3 cycles with both requests high -> mem_access, disp_ack and cpu_ack stay 0 and the state is IDLE. Release -> display is granted first; mem_access is high 1 cycle later with mem_address = disp_address.
- Solo CPU write: cpu_access with address 16'h0123, bytesel 2'b01, data 16'hBEEF, memory acks after 2 cycles -> mem_wr_en = 1, mem_bytesel = 2'b01, mem_wr_data = 16'hBEEF; a single cpu_ack pulse arrives 1 cycle after mem_ack.
- Display read: disp_access at address 16'h0400, memory returns 16'h1F41 -> disp_data = 16'h1F41 with a 1-cycle disp_ack; cpu_ack stays 0.
- Burst limit: disp_access held continuously, cpu_access raised, 1-cycle memory -> exactly 8 display grants, then one CPU grant, then display resumes.
- Starvation: DISP_BURST_MAX = 64, CPU_STARVE_LIMIT = 32, slow memory (10-cycle ack), both requests held -> CPU is granted at the first IDLE after starve_cnt reaches 32; starve_cnt then reads 0.
- Reset mid-operation: assert reset = 0 while in CPU, one cycle before mem_ack -> no cpu_ack; mem_access drops on that reset edge and the state is IDLE; after release, a fresh CPU request completes normally.
